reg_dump_unit: RTL and testbench

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

---
 rtl/reg_dump_unit.sv | 136 +++++++++++++
 tb/tb_reg_dump_unit.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_unit.sv
`timescale 1ns/1ps
// Streams every register of a register file out through a byte-wide
// UART transmitter, least-significant byte first, ascending address.
module reg_dump_unit #(
    parameter int WIDTH         = 32,
    parameter int WIDTH_ADD     = 5,
    parameter int NUM_REGISTERS = 32,
    parameter int BYTE          = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [WIDTH_ADD-1:0] reg_addr,
    input  logic [WIDTH-1:0]     reg_data,
    output logic                 tx_start,
    output logic [BYTE-1:0]      tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 done
);

    localparam int NBYTES = WIDTH / BYTE;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0]        LAST_BYTE = CW'(NBYTES - 1);
    localparam logic [WIDTH_ADD-1:0] LAST_ADDR = WIDTH_ADD'(NUM_REGISTERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        NEXT,
        FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH_ADD-1:0] addr_q, addr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        cnt_inc;
    logic [WIDTH-1:0]     hold_q, hold_d;
    logic [BYTE-1:0]      txd_q, txd_d;
    logic                 txs_q, txs_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    assign cnt_inc = cnt_q + CW'(1);

    // tx_start/tx_data are computed one state early so they are registered
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        txd_d   = txd_q;
        txs_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                hold_d  = reg_data;
                txd_d   = reg_data[BYTE*cnt_q +: BYTE];
                txs_d   = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = NEXT;
                    end else begin
                        cnt_d   = cnt_inc;
                        txd_d   = hold_q[BYTE*cnt_inc +: BYTE];
                        txs_d   = 1'b1;
                        state_d = SEND;
                    end
                end
            end
            NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    done_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    addr_d  = addr_q + WIDTH_ADD'(1);
                    state_d = LOAD;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            txd_q   <= '0;
            txs_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            txd_q   <= txd_d;
            txs_q   <= txs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign reg_addr = addr_q;
    assign tx_start = txs_q;
    assign tx_data  = txd_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
`timescale 1ns/1ps
// Bench for reg_dump_unit: register file and UART transmitter models,
// expected byte stream derived from register contents.
module tb_reg_dump_unit;

    localparam int WIDTH = 32;
    localparam int WA    = 5;
    localparam int NR    = 32;
    localparam int BYTE  = 8;
    localparam int NB    = WIDTH / BYTE;
    localparam int TOTAL = NR * NB;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [WA-1:0]     reg_addr;
    logic [WIDTH-1:0]  reg_data;
    logic              tx_start;
    logic [BYTE-1:0]   tx_data;
    logic              tx_done;
    logic              busy;
    logic              done;

    logic [WIDTH-1:0]  rf [NR];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         tcyc_q[$];
    int         done_cnt;
    int         busy_at_done;
    int         busy_after_done;
    bit         timed_out;

    assign reg_data = rf[reg_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_dump_unit #(
        .WIDTH(WIDTH),
        .WIDTH_ADD(WA),
        .NUM_REGISTERS(NR),
        .BYTE(BYTE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .reg_addr(reg_addr),
        .reg_data(reg_data),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_done(tx_done),
        .busy(busy),
        .done(done)
    );

    task automatic fill_fixed();
        for (int i = 0; i < NR; i++) rf[i] = 32'h11223300 + i;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NR; i++) rf[i] = $urandom;
    endtask

    // Expected stream: every register, low byte first, ascending address
    task automatic build_model();
        exp_q.delete();
        for (int i = 0; i < NR; i++)
            for (int b = 0; b < NB; b++)
                exp_q.push_back(rf[i][8*b +: 8]);
    endtask

    task automatic apply_reset();
        start   = 1'b0;
        tx_done = 1'b0;
        reset   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Pulses start, acts as a transmitter answering tx_start after lat
    // cycles (lat=0: never answers), and records what the DUT emits.
    task automatic drive_dump(input int lat, input bit keep_start,
                              input int stop_bytes, input int budget);
        int cd;
        int n;
        bit prev_done;
        cd = 0;
        n = 0;
        prev_done = 0;
        got_q.delete();
        tcyc_q.delete();
        done_cnt = 0;
        busy_at_done = -1;
        busy_after_done = -1;
        timed_out = 0;
        start = 1'b1;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (!keep_start) start = 1'b0;
            tx_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) tx_done = 1'b1;
            end
            if (tx_start) begin
                got_q.push_back(tx_data);
                tcyc_q.push_back(cyc);
                cd = lat;
            end
            if (prev_done) begin
                busy_after_done = int'(busy);
                break;
            end
            if (done) begin
                done_cnt++;
                busy_at_done = int'(busy);
                prev_done = 1;
            end
            if (stop_bytes > 0 && got_q.size() == stop_bytes) break;
            if (n >= budget) begin
                timed_out = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        tx_done = 1'b0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({reg_addr, tx_start, tx_data, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {reg_addr, tx_start, tx_data, busy, done});
        end
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || tx_start !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_reset busy=%b tx_start=%b exp 0 0",
                         busy, tx_start);
            end
        end
    endtask

    task automatic test_full_dump();
        logic [7:0] first4 [4];
        logic [7:0] last4 [4];
        int bad;
        first4 = '{8'h00, 8'h33, 8'h22, 8'h11};
        last4  = '{8'h1F, 8'h33, 8'h22, 8'h11};
        fill_fixed();
        build_model();
        drive_dump(10, 1'b0, 0, 3000);
        checks++;
        if (timed_out) begin
            failures++;
            $display("FAIL full_timeout got=timeout exp=done");
        end
        checks++;
        if (got_q.size() != TOTAL) begin
            failures++;
            $display("FAIL full_count got=%0d exp=%0d", got_q.size(), TOTAL);
        end
        for (int k = 0; k < TOTAL; k++) begin
            checks++;
            if (k >= got_q.size()) begin
                failures++;
                $display("FAIL full_byte[%0d] got=missing exp=%h", k, exp_q[k]);
            end else if (got_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL full_byte[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]);
            end
        end
        if (got_q.size() == TOTAL) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got_q[k] !== first4[k]) begin
                    failures++;
                    $display("FAIL full_first[%0d] got=%h exp=%h", k, got_q[k], first4[k]);
                end
                checks++;
                if (got_q[TOTAL-4+k] !== last4[k]) begin
                    failures++;
                    $display("FAIL full_last[%0d] got=%h exp=%h",
                             k, got_q[TOTAL-4+k], last4[k]);
                end
            end
        end
        bad = 0;
        for (int k = 1; k < tcyc_q.size(); k++)
            if (tcyc_q[k] - tcyc_q[k-1] != ((k % NB == 0) ? 13 : 11)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL full_spacing got=%0d bad gaps exp=0", bad);
        end
        checks++;
        if (done_cnt != 1 || busy_at_done != 1 || busy_after_done != 0) begin
            failures++;
            $display("FAIL full_done got=cnt%0d busy%0d/%0d exp=cnt1 busy1/0",
                     done_cnt, busy_at_done, busy_after_done);
        end
    endtask

    task automatic test_zero_latency();
        int bad;
        fill_random();
        build_model();
        drive_dump(1, 1'b0, 0, 2000);
        checks++;
        if (timed_out || got_q.size() != TOTAL) begin
            failures++;
            $display("FAIL zl_count got=%0d timeout=%0d exp=%0d",
                     got_q.size(), timed_out, TOTAL);
        end
        bad = 0;
        for (int k = 0; k < got_q.size() && k < TOTAL; k++)
            if (got_q[k] !== exp_q[k]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL zl_bytes got=%0d wrong exp=0", bad);
        end
        bad = 0;
        for (int k = 1; k < tcyc_q.size(); k++)
            if (tcyc_q[k] - tcyc_q[k-1] != ((k % NB == 0) ? 4 : 2)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL zl_spacing got=%0d bad gaps exp=0", bad);
        end
        checks++;
        if (done_cnt != 1 || busy_after_done != 0) begin
            failures++;
            $display("FAIL zl_done got=cnt%0d busy_after%0d exp=cnt1 busy_after0",
                     done_cnt, busy_after_done);
        end
    endtask

    task automatic test_spurious_done();
        fill_random();
        start = 1'b0;
        tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        repeat (3) begin
            checks++;
            if (busy !== 1'b0 || tx_start !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL spur_idle busy=%b tx_start=%b done=%b exp 0 0 0",
                         busy, tx_start, done);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tx_done = 1'b1;
        checks++;
        if (busy !== 1'b1 || tx_start !== 1'b0) begin
            failures++;
            $display("FAIL spur_load busy=%b tx_start=%b exp 1 0", busy, tx_start);
        end
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== rf[0][7:0]) begin
            failures++;
            $display("FAIL spur_send got=%b/%h exp=1/%h", tx_start, tx_data, rf[0][7:0]);
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            checks++;
            if (tx_start !== 1'b0) begin
                failures++;
                $display("FAIL spur_extra got=tx_start %b exp=0", tx_start);
            end
        end
        apply_reset();
    endtask

    task automatic test_ignored_start();
        int bad;
        fill_random();
        build_model();
        drive_dump($urandom_range(1, 3), 1'b1, 0, 3000);
        checks++;
        if (timed_out || got_q.size() != TOTAL) begin
            failures++;
            $display("FAIL ign_count got=%0d timeout=%0d exp=%0d",
                     got_q.size(), timed_out, TOTAL);
        end
        bad = 0;
        for (int k = 0; k < got_q.size() && k < TOTAL; k++)
            if (got_q[k] !== exp_q[k]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ign_bytes got=%0d wrong exp=0", bad);
        end
        checks++;
        if (done_cnt != 1 || busy_after_done != 0) begin
            failures++;
            $display("FAIL ign_done got=cnt%0d busy_after%0d exp=cnt1 busy_after0",
                     done_cnt, busy_after_done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ign_restart got=busy %b exp=1", busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== rf[0][7:0]) begin
            failures++;
            $display("FAIL ign_second got=%b/%h exp=1/%h", tx_start, tx_data, rf[0][7:0]);
        end
        apply_reset();
    endtask

    task automatic test_stability();
        logic [7:0] d;
        fill_random();
        drive_dump(0, 1'b0, 1, 100);
        d = tx_data;
        checks++;
        if (got_q.size() != 1 || d !== rf[0][7:0]) begin
            failures++;
            $display("FAIL stab_first got=%0d/%h exp=1/%h", got_q.size(), d, rf[0][7:0]);
        end
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tx_start !== 1'b0 || tx_data !== d) begin
                failures++;
                $display("FAIL stab_hold[%0d] got=%b/%h exp=0/%h", k, tx_start, tx_data, d);
            end
        end
        tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== rf[0][15:8]) begin
            failures++;
            $display("FAIL stab_resume got=%b/%h exp=1/%h", tx_start, tx_data, rf[0][15:8]);
        end
        apply_reset();
    endtask

    task automatic test_mid_reset();
        int bad;
        fill_random();
        drive_dump(3, 1'b0, 5*NB + 3, 2000);
        checks++;
        if (got_q.size() != 5*NB + 3 || got_q[got_q.size()-1] !== rf[5][23:16]) begin
            failures++;
            $display("FAIL mid_prefix got=%0d/%h exp=%0d/%h",
                     got_q.size(), got_q[got_q.size()-1], 5*NB + 3, rf[5][23:16]);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({reg_addr, tx_start, tx_data, busy, done} !== '0) begin
            failures++;
            $display("FAIL mid_async got=%h exp=0",
                     {reg_addr, tx_start, tx_data, busy, done});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            checks++;
            if (tx_start !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_quiet got=%b%b%b exp=000", tx_start, done, busy);
            end
        end
        fill_random();
        build_model();
        drive_dump(2, 1'b0, 0, 3000);
        bad = 0;
        for (int k = 0; k < got_q.size() && k < TOTAL; k++)
            if (got_q[k] !== exp_q[k]) bad++;
        checks++;
        if (timed_out || got_q.size() != TOTAL || bad != 0) begin
            failures++;
            $display("FAIL mid_redump got=%0d bytes %0d wrong exp=%0d 0",
                     got_q.size(), bad, TOTAL);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL mid_redone got=%0d exp=1", done_cnt);
        end
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_dump();
        test_zero_latency();
        test_spurious_done();
        test_ignored_start();
        test_stability();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
